// File: rtl/udma_lsu_pkg.sv
// Shared types and width helpers for the uDMA LSU arbiter and LSU tap.
package udma_lsu_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } lsu_arb_state_e;

  localparam int LSU_NREQ    = 2;
  localparam int LSU_MAX_OUT = 4;

  // Index width that stays at least one bit wide for single-entry ranges.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/udma_lsu_owner_fifo.sv
// In-order owner-ID FIFO: remembers which requester owns each outstanding response.
module udma_lsu_owner_fifo
  import udma_lsu_pkg::*;
#(
  parameter int  DEPTH = LSU_MAX_OUT,
  parameter int  WIDTH = 1,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  localparam int PW = idx_w(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_push_s;
  logic             do_pop_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty_o   = (count_r == CW'(0));
  assign full_o    = (count_r == CW'(DEPTH));
  assign count_o   = count_r;
  assign head_o    = mem_r[rd_ptr_r];
  assign do_pop_s  = pop_i & ~empty_o;
  // A push into a full FIFO is only legal when a pop frees a slot in the same cycle.
  assign do_push_s = push_i & (~full_o | do_pop_s);

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= data_i;
        wr_ptr_r        <= ptr_inc(wr_ptr_r);
      end
      if (do_pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/udma_lsu_arb.sv
// Round-robin arbiter sharing one LSU master port between NREQ requesters,
// with in-order response routing through an owner-ID FIFO.
module udma_lsu_arb
  import udma_lsu_pkg::*;
#(
  parameter int NREQ    = LSU_NREQ,
  parameter int MAX_OUT = LSU_MAX_OUT,
  parameter int AW      = 32,
  parameter int DW      = 32
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               en_i,
  input  logic [NREQ-1:0]    req_i,
  input  logic [NREQ-1:0]    we_i,
  input  logic [NREQ*AW-1:0] addr_i,
  input  logic [NREQ*DW-1:0] wdata_i,
  output logic [NREQ-1:0]    gnt_o,
  output logic [NREQ-1:0]    rvalid_o,
  output logic [DW-1:0]      rdata_o,
  output logic               req_o,
  output logic               we_o,
  output logic [AW-1:0]      addr_o,
  output logic [DW-1:0]      wdata_o,
  input  logic               gnt_i,
  input  logic               rvalid_i,
  input  logic [DW-1:0]      rdata_i,
  output logic               busy_o,
  output logic               err_o
);

  localparam int SW = idx_w(NREQ);
  localparam int CW = $clog2(MAX_OUT) + 1;

  lsu_arb_state_e state_r, state_nxt_s;
  logic [SW-1:0]  sel_r, sel_nxt_s;
  logic [SW-1:0]  rr_ptr_r, rr_ptr_nxt_s;
  logic           err_r;
  logic           push_s;
  logic           pop_s;
  logic [SW-1:0]  fifo_head_s;
  logic           fifo_full_s;
  logic           fifo_empty_s;
  logic [CW-1:0]  fifo_cnt_s;

  // First set request at or after ptr, wrapping; only called when some request is set.
  function automatic logic [SW-1:0] rr_pick(input logic [NREQ-1:0] req, input logic [SW-1:0] ptr);
    logic [SW-1:0] res;
    logic          found;
    int            idx;
    res   = ptr;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      idx   = (int'(ptr) + i) % NREQ;
      res   = (!found && req[idx]) ? SW'(idx) : res;
      found = found | req[idx];
    end
    return res;
  endfunction

  udma_lsu_owner_fifo #(
    .DEPTH (MAX_OUT),
    .WIDTH (SW)
  ) u_owner_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .data_i  (sel_r),
    .head_o  (fifo_head_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .count_o (fifo_cnt_s)
  );

  // Arbitration state, selection, round-robin pointer and sticky error.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_r  <= IDLE;
      sel_r    <= '0;
      rr_ptr_r <= '0;
      err_r    <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      sel_r    <= sel_nxt_s;
      rr_ptr_r <= rr_ptr_nxt_s;
      err_r    <= err_r | (rvalid_i & fifo_empty_s);
    end
  end

  // Next-state logic and master-side request mux.
  always_comb begin
    state_nxt_s  = state_r;
    sel_nxt_s    = sel_r;
    rr_ptr_nxt_s = rr_ptr_r;
    push_s       = 1'b0;
    gnt_o        = '0;
    req_o        = 1'b0;
    we_o         = 1'b0;
    addr_o       = '0;
    wdata_o      = '0;
    case (state_r)
      IDLE: begin
        // Not full means a later grant always has a FIFO slot.
        if (en_i && !fifo_full_s && (|req_i)) begin
          sel_nxt_s   = rr_pick(req_i, rr_ptr_r);
          state_nxt_s = LOCK;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      LOCK: begin
        req_o   = 1'b1;
        we_o    = we_i[sel_r];
        addr_o  = addr_i[int'(sel_r)*AW +: AW];
        wdata_o = wdata_i[int'(sel_r)*DW +: DW];
        if (gnt_i) begin
          gnt_o        = NREQ'(1'b1) << sel_r;
          push_s       = 1'b1;
          rr_ptr_nxt_s = (sel_r == SW'(NREQ - 1)) ? '0 : sel_r + SW'(1);
          state_nxt_s  = IDLE;
        end else begin
          state_nxt_s = LOCK;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  assign pop_s    = rvalid_i & ~fifo_empty_s;
  assign rvalid_o = pop_s ? (NREQ'(1'b1) << fifo_head_s) : '0;
  assign rdata_o  = pop_s ? rdata_i : '0;
  assign busy_o   = (fifo_cnt_s != CW'(0)) | req_o;
  assign err_o    = err_r;

endmodule

// File: tb/tb_udma_lsu_arb.sv
// Directed self-checking bench for udma_lsu_arb with an owner scoreboard.
module tb_udma_lsu_arb;

  localparam int NREQ = 2;
  localparam int AW   = 32;
  localparam int DW   = 32;

  logic               clk_i = 1'b0;
  logic               rstn_i = 1'b0;
  logic               en_i = 1'b0;
  logic [NREQ-1:0]    req_i = '0;
  logic [NREQ-1:0]    we_i = '0;
  logic [NREQ*AW-1:0] addr_i = '0;
  logic [NREQ*DW-1:0] wdata_i = '0;
  logic [NREQ-1:0]    gnt_o;
  logic [NREQ-1:0]    rvalid_o;
  logic [DW-1:0]      rdata_o;
  logic               req_o;
  logic               we_o;
  logic [AW-1:0]      addr_o;
  logic [DW-1:0]      wdata_o;
  logic               gnt_i = 1'b0;
  logic               rvalid_i = 1'b0;
  logic [DW-1:0]      rdata_i = '0;
  logic               busy_o;
  logic               err_o;

  int checks = 0;
  int errors = 0;
  int owner_q[$];

  udma_lsu_arb #(.NREQ(NREQ), .MAX_OUT(4), .AW(AW), .DW(DW)) dut (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .en_i     (en_i),
    .req_i    (req_i),
    .we_i     (we_i),
    .addr_i   (addr_i),
    .wdata_i  (wdata_i),
    .gnt_o    (gnt_o),
    .rvalid_o (rvalid_o),
    .rdata_o  (rdata_o),
    .req_o    (req_o),
    .we_o     (we_o),
    .addr_o   (addr_o),
    .wdata_o  (wdata_o),
    .gnt_i    (gnt_i),
    .rvalid_i (rvalid_i),
    .rdata_i  (rdata_i),
    .busy_o   (busy_o),
    .err_o    (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk_i);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".req_o"}, 64'(req_o), 64'd0);
    chk({tag, ".we_o"}, 64'(we_o), 64'd0);
    chk({tag, ".addr_o"}, 64'(addr_o), 64'd0);
    chk({tag, ".wdata_o"}, 64'(wdata_o), 64'd0);
    chk({tag, ".gnt_o"}, 64'(gnt_o), 64'd0);
    chk({tag, ".rvalid_o"}, 64'(rvalid_o), 64'd0);
    chk({tag, ".rdata_o"}, 64'(rdata_o), 64'd0);
    chk({tag, ".busy_o"}, 64'(busy_o), 64'd0);
    chk({tag, ".err_o"}, 64'(err_o), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rstn_i   = 1'b0;
    req_i    = '0;
    we_i     = '0;
    gnt_i    = 1'b0;
    rvalid_i = 1'b0;
    owner_q.delete();
    #1 chk_zero("reset");
    @(negedge clk_i);
    rstn_i = 1'b1;
    en_i   = 1'b1;
  endtask

  // Expects a grant to the given owner in the current cycle and records it.
  task automatic grant_chk(input int owner);
    chk("gnt_o", 64'(gnt_o), 64'(2'b01 << owner));
    chk("req_o_grant", 64'(req_o), 64'd1);
    owner_q.push_back(owner);
  endtask

  // Drives one response and compares routing against the scoreboard head.
  task automatic resp(input logic [31:0] data);
    int owner;
    rvalid_i = 1'b1;
    rdata_i  = data;
    #1;
    if (owner_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty observed=%h expected=owner", rvalid_o);
    end else begin
      owner = owner_q.pop_front();
      chk("rvalid_o", 64'(rvalid_o), 64'(2'b01 << owner));
      chk("rdata_o", 64'(rdata_o), 64'(data));
    end
  endtask

  initial begin
    do_reset();

    // Single request with bus grant tied high.
    gnt_i = 1'b1;
    cyc(); req_i = 2'b01; addr_i[0 +: AW] = 32'h1A00_0010; we_i = 2'b01;
    wdata_i[0 +: DW] = 32'h0000_1234;
    #1 chk("t1_req_o_latency", 64'(req_o), 64'd0);
    cyc(); #1 grant_chk(0);
    chk("t1_addr_o", 64'(addr_o), 64'h1A00_0010);
    chk("t1_we_o", 64'(we_o), 64'd1);
    chk("t1_wdata_o", 64'(wdata_o), 64'h1234);
    chk("t1_busy_o", 64'(busy_o), 64'd1);
    cyc(); req_i = 2'b00; #1 chk("t1_req_o_idle", 64'(req_o), 64'd0);
    cyc(); resp(32'hDEAD_BEEF);
    cyc(); rvalid_i = 1'b0; #1 chk("t1_rvalid_off", 64'(rvalid_o), 64'd0);
    chk("t1_busy_done", 64'(busy_o), 64'd0);
    chk("t1_rdata_off", 64'(rdata_o), 64'd0);

    // Fairness with both requesters held and immediate responses.
    do_reset();
    gnt_i = 1'b1; we_i = 2'b00;
    cyc(); req_i = 2'b11; #1 chk("t2_idle_gnt", 64'(gnt_o), 64'd0);
    for (int k = 0; k < 4; k++) begin
      cyc(); rvalid_i = 1'b0; #1 grant_chk(k % 2);
      cyc(); resp(32'h100 + 32'(k));
      chk("t2_idle_gnt", 64'(gnt_o), 64'd0);
    end

    // Selection held while the bus stalls.
    do_reset();
    gnt_i = 1'b0;
    addr_i[0 +: AW]  = 32'h1A00_0100;
    addr_i[AW +: AW] = 32'h1A00_0200;
    cyc(); req_i = 2'b01; #1;
    for (int i = 0; i < 5; i++) begin
      cyc(); if (i == 1) req_i = 2'b11; #1;
      chk("t3_lock_req_o", 64'(req_o), 64'd1);
      chk("t3_lock_addr_o", 64'(addr_o), 64'h1A00_0100);
      chk("t3_lock_gnt_o", 64'(gnt_o), 64'd0);
    end
    cyc(); gnt_i = 1'b1; #1 grant_chk(0);
    cyc(); req_i = 2'b10; #1 chk("t3_idle_req_o", 64'(req_o), 64'd0);
    cyc(); #1 grant_chk(1);
    chk("t3_addr1", 64'(addr_o), 64'h1A00_0200);
    cyc(); req_i = 2'b00; resp(32'hAAAA_0000);
    cyc(); resp(32'hBBBB_1111);

    // Throttle at four outstanding, then in-order drain.
    do_reset();
    gnt_i = 1'b1;
    cyc(); req_i = 2'b11; #1;
    for (int k = 0; k < 4; k++) begin
      cyc(); #1 grant_chk(k % 2);
      cyc(); #1 chk("t4_idle_gnt", 64'(gnt_o), 64'd0);
    end
    cyc(); #1 chk("t4_full_req_o", 64'(req_o), 64'd0);
    chk("t4_full_busy", 64'(busy_o), 64'd1);
    cyc(); #1 chk("t4_full_req_o2", 64'(req_o), 64'd0);
    for (int k = 0; k < 4; k++) begin
      cyc(); req_i = 2'b00; resp(32'(k + 1));
    end
    cyc(); rvalid_i = 1'b0; #1 chk("t4_drained_busy", 64'(busy_o), 64'd0);

    // Push and pop in the same cycle with two outstanding.
    do_reset();
    gnt_i = 1'b1;
    cyc(); req_i = 2'b01; #1;
    cyc(); #1 grant_chk(0);
    cyc(); req_i = 2'b10; #1;
    cyc(); #1 grant_chk(1);
    cyc(); req_i = 2'b01; #1;
    cyc(); resp(32'h55); grant_chk(0);
    cyc(); req_i = 2'b00; resp(32'h66);
    cyc(); resp(32'h77);
    cyc(); rvalid_i = 1'b1; rdata_i = 32'h99;
    #1 chk("t5_orphan_rvalid", 64'(rvalid_o), 64'd0);
    chk("t5_orphan_rdata", 64'(rdata_o), 64'd0);
    cyc(); rvalid_i = 1'b0; #1 chk("t5_err_o", 64'(err_o), 64'd1);

    // Enable low: no new selection, responses still routed, locked request completes.
    do_reset();
    gnt_i = 1'b1;
    cyc(); req_i = 2'b01; #1;
    cyc(); #1 grant_chk(0);
    cyc(); en_i = 1'b0; #1 chk("t6_dis_req_o", 64'(req_o), 64'd0);
    cyc(); #1 chk("t6_dis_req_o2", 64'(req_o), 64'd0);
    chk("t6_dis_busy", 64'(busy_o), 64'd1);
    cyc(); resp(32'hCAFE_F00D);
    chk("t6_dis_req_o3", 64'(req_o), 64'd0);
    cyc(); rvalid_i = 1'b0; #1 chk("t6_dis_busy_done", 64'(busy_o), 64'd0);
    cyc(); gnt_i = 1'b0; en_i = 1'b1; #1 chk("t6_en_idle", 64'(req_o), 64'd0);
    cyc(); en_i = 1'b0; #1 chk("t6_lock_req_o", 64'(req_o), 64'd1);
    cyc(); #1 chk("t6_lock_held_dis", 64'(req_o), 64'd1);
    chk("t6_lock_addr", 64'(addr_o), 64'h1A00_0100);
    rstn_i = 1'b0; req_i = 2'b00; owner_q.delete();
    #1 chk_zero("t6_midlock_reset");
    cyc(); rstn_i = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/udma_lsu_arb.md
Name: udma_lsu_arb

Overview:
Arbiter that shares one LSU memory port (req/gnt/addr/data/valid) between NREQ requesters, e.g. the UART LSU tap and a second debug master. Round-robin selection, with the choice held until the bus grants. Response routing is in order, through an owner-ID FIFO, so multiple transactions can be outstanding. Sits between the requesters and the L2/peripheral interconnect master port.

Parameters:
NREQ, 2, number of requesters (2..8)
MAX_OUT, 4, max outstanding granted-but-unanswered transactions (power of 2, >=1)
AW, 32, address width
DW, 32, data width

Ports:
clk_i  in  1  clock
rstn_i  in  1  asynchronous active-low reset
en_i  in  1  arbiter enable; low = accept no new requests, drain outstanding
req_i  in  NREQ  per-requester request, held until gnt_o
we_i  in  NREQ  per-requester write enable
addr_i  in  NREQ*AW  per-requester address, slice k = requester k
wdata_i  in  NREQ*DW  per-requester write data
gnt_o  out  NREQ  per-requester grant (one-hot or zero)
rvalid_o  out  NREQ  per-requester response valid (one-hot or zero)
rdata_o  out  DW  response data, broadcast to all requesters
req_o  out  1  master request
we_o  out  1  master write enable
addr_o  out  AW  master address
wdata_o  out  DW  master write data
gnt_i  in  1  master grant
rvalid_i  in  1  master response valid, one per granted transaction, in order
rdata_i  in  DW  master response data
busy_o  out  1  outstanding count != 0 or req_o high
err_o  out  1  sticky: rvalid_i received while owner FIFO empty

Behaviour:
- Reset values: sel=0, rr_ptr=0, state IDLE, FIFO empty, count=0, err_o=0.
- With those values every output reads 0: req_o, we_o, addr_o, wdata_o, gnt_o, rvalid_o, rdata_o, busy_o.
- States:
  - IDLE: when en_i=1, count<MAX_OUT and any req_i is set, pick the first set req_i at or after rr_ptr (wrapping), latch sel, go to LOCK. The pick is combinational and req_o rises in the next cycle (1-cycle arbitration latency).
  - LOCK: req_o=1; we_o/addr_o/wdata_o are a combinational mux of requester sel.
    - gnt_i=1: gnt_o[sel]=1 for that cycle; push sel into the owner FIFO; rr_ptr=(sel+1) mod NREQ; go to IDLE.
    - gnt_i=0: stay in LOCK. The selection never changes while locked, even if a higher-priority request appears.
- gnt_o is only ever asserted in LOCK with gnt_i=1. A requester sees exactly one gnt_o per transaction.
- Response path: rvalid_i=1 with FIFO non-empty gives rvalid_o[fifo_head]=1 in the same cycle (combinational), rdata_o=rdata_i, and pops the FIFO. Otherwise rdata_o=0.
- Response with empty FIFO: rvalid_i ignored (no rvalid_o); err_o set until reset.
- Push and pop in the same cycle: both happen, count unchanged.
- Throttle: with count==MAX_OUT, IDLE does not select. A grant can never overflow the FIFO because selection requires count<MAX_OUT and at most one push can follow a selection.
- en_i low:
  - In IDLE: no new selection.
  - In LOCK: the locked request completes (the bus contract forbids dropping req_o before gnt_i).
  - Responses continue to be routed while en_i is low.
- Requester drops req_i while locked: protocol violation. The arbiter keeps req_o asserted to completion; the verification bench must not generate this case.
- Owner FIFO:
  - Depth MAX_OUT, entry width clog2(NREQ).
  - Read/write pointers clog2(MAX_OUT) bits, wrapping naturally; count is clog2(MAX_OUT)+1 bits.
- Reset mid-operation: all state cleared asynchronously; in-flight responses after reset take the err_o path.

Decomposition:
- Package udma_lsu_pkg: state enum (IDLE, LOCK) and the clog2-derived width localparams shared with the LSU tap.
- Sub-module udma_lsu_owner_fifo: sync FIFO with push/pop/full/empty/count and head output, same clk/async reset.
- Round-robin pick stays inline as a function.

Test Plan:
1. Single request: req_i=01, addr_i[0]=0x1A00_0010, gnt_i tied 1. Expect req_o high 1 cycle after req_i, addr_o=0x1A00_0010, gnt_o=01 that cycle. A later rvalid_i with rdata_i=0xDEAD_BEEF gives rvalid_o=01, rdata_o=0xDEAD_BEEF.
2. Fairness: req_i=11 held continuously, gnt_i=1, immediate responses. Expect gnt_o sequence 01,10,01,10; rr_ptr alternates.
3. Lock: req_i=01 selected, gnt_i=0 for 5 cycles, then req_i=11. Expect req_o/addr_o stay on requester 0 until gnt_i; gnt_o=01; requester 1 served next.
4. Outstanding/order: MAX_OUT=4, grant 4 transactions (0,1,0,1) with no rvalid_i. Expect a 5th request not selected and busy_o=1. Then 4 rvalid_i with data 1..4 give rvalid_o=01,10,01,10 carrying 1..4 in order.
5. Simultaneous push/pop: rvalid_i on the same cycle as gnt_i with count=2. Expect count stays 2 and routing stays correct.
6. Error/enable: rvalid_i with FIFO empty sets err_o=1 and rvalid_o=00. en_i=0 with req_i=01 gives no req_o while pending responses still route. Asserting rstn_i low mid-LOCK returns all outputs to 0.
